// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
package calc_pkg;

    // Per-slot scan phase: dark anti-ghosting gap, then the digit is lit.
    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_e;

    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [1:0] STATUS_ERR = 2'b11;

    // Active-low: all segments dark, all digit enables released.
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low one-hot enable for a single digit.
    function automatic logic [7:0] digit_enable(input logic [2:0] idx);
        digit_enable = ~(8'b0000_0001 << idx);
    endfunction

endpackage

// File: rtl/blink_gen.sv
// Free-running blink source used to flash the display on a calculator error.
// blink_off toggles every BLINK_DIV cycles and is independent of the scan timing.
module blink_gen #(
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic clock,
    input  logic reset,
    output logic blink_off
);

    logic [31:0] cnt_q, cnt_d;
    logic        blink_off_q, blink_off_d;

    // Count up to BLINK_DIV-1, then wrap and flip the blink phase.
    always_comb begin
        cnt_d       = cnt_q + 32'd1;
        blink_off_d = blink_off_q;
        if (cnt_q == BLINK_DIV - 1) begin
            cnt_d       = '0;
            blink_off_d = ~blink_off_q;
        end
    end

    // Counter and phase registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            blink_off_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    assign blink_off = blink_off_q;

endmodule

// File: rtl/display_scan.sv
// Eight-digit seven-segment scanner. Each digit slot is a short blank gap
// followed by the lit period; the segment data for a whole frame is latched
// into a shadow copy at the frame start so mid-frame updates never tear.
module display_scan
    import calc_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned BLINK_DIV    = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] displays [7:0],
    input  logic [1:0] status,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    scan_state_e state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic [6:0]  shadow_q [NUM_DIGITS];
    logic [6:0]  shadow_d [NUM_DIGITS];

    logic [7:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        tick_q, tick_d;

    logic        frame_start;
    logic        blink_off;

    blink_gen #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_gen (
        .clock     (clock),
        .reset     (reset),
        .blink_off (blink_off)
    );

    // First cycle of the blank phase of digit 0; also the first cycle out of reset.
    assign frame_start = (state_q == S_BLANK) && (idx_q == 3'd0) && (cnt_q == 32'd0);

    // Slot timing: the counter runs across the whole slot and only clears at its end,
    // so the blank->on transition costs no cycle and the frame is exactly 8*CLK_DIV.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 32'd1;
        unique case (state_q)
            S_BLANK: begin
                if (cnt_q == BLANK_CYCLES - 1) begin
                    state_d = S_ON;
                end
            end
            S_ON: begin
                if (cnt_q == CLK_DIV - 1) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                end
            end
            default: begin
                state_d = S_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Latch all digit patterns once per frame.
    always_comb begin
        shadow_d = shadow_q;
        if (frame_start) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_d[i] = displays[i];
            end
        end
    end

    // Pin values for the next cycle; error blink only masks the digit enables.
    always_comb begin
        an_d   = AN_OFF;
        seg_d  = SEG_OFF;
        tick_d = frame_start;
        if (state_q == S_ON) begin
            an_d  = digit_enable(idx_q);
            seg_d = shadow_q[idx_q];
        end
        if ((status == STATUS_ERR) && blink_off) begin
            an_d = AN_OFF;
        end
    end

    // Scan state, shadow copy and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_BLANK;
            idx_q   <= '0;
            cnt_q   <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            tick_q  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= SEG_OFF;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            tick_q   <= tick_d;
            shadow_q <= shadow_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = tick_q;
    assign dp         = 1'b1;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan with a cycle-count based reference model.
module tb_display_scan;

    localparam int unsigned CLK_DIV      = 4;
    localparam int unsigned BLANK_CYCLES = 1;
    localparam int unsigned BLINK_DIV    = 16;
    localparam int unsigned FRAME        = 8 * CLK_DIV;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] displays [7:0];
    logic [1:0] status = 2'b00;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    display_scan #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_DIV    (BLINK_DIV)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .displays   (displays),
        .status     (status),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clock = ~clock;

    // Reference model: k counts clock edges since reset release; every output
    // follows from k by plain arithmetic on slot length, frame length and blink period.
    int unsigned k = 0;
    logic [6:0]  m_shadow [8];
    logic [7:0]  exp_an   = 8'hFF;
    logic [6:0]  exp_seg  = 7'h7F;
    logic        exp_tick = 1'b0;
    int          en_cnt [8];

    always @(posedge clock) begin
        int unsigned slot;
        int unsigned pos;
        bit          blink;
        if (reset) begin
            k        = 0;
            exp_an   = 8'hFF;
            exp_seg  = 7'h7F;
            exp_tick = 1'b0;
            for (int i = 0; i < 8; i++) m_shadow[i] = 7'h7F;
        end else begin
            slot  = (k / CLK_DIV) % 8;
            pos   = k % CLK_DIV;
            blink = ((k / BLINK_DIV) % 2) == 1;
            if ((k % FRAME) == 0) begin
                for (int i = 0; i < 8; i++) m_shadow[i] = displays[i];
            end
            exp_tick = ((k % FRAME) == 0);
            exp_seg  = (pos < BLANK_CYCLES) ? 7'h7F : m_shadow[slot];
            exp_an   = (pos < BLANK_CYCLES) ? 8'hFF : ~(8'h01 << slot);
            if (status == 2'b11 && blink) exp_an = 8'hFF;
            k++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle and compare all outputs on the falling edge.
    task automatic step();
        @(negedge clock);
        check("an", 32'(an), 32'(exp_an));
        check("seg", 32'(seg), 32'(exp_seg));
        check("frame_tick", 32'(frame_tick), 32'(exp_tick));
        check("dp", 32'(dp), 32'd1);
        check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (!an[i]) en_cnt[i]++;
        end
    endtask

    function automatic int unsigned next_slot();
        return (k % FRAME) / CLK_DIV;
    endfunction

    initial begin
        bit found;
        for (int i = 0; i < 8; i++) displays[i] = 7'(8'h10 + i * 8'h0B);

        // Reset for two cycles.
        repeat (2) step();
        check("rst_an", 32'(an), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_tick", 32'(frame_tick), 32'd0);

        // Release: frame start is visible on the first edge.
        reset = 1'b0;
        step();
        check("first_tick", 32'(frame_tick), 32'd1);
        check("first_blank", 32'(an), 32'hFF);
        step();
        check("digit0_on", 32'(an), 32'hFE);
        check("digit0_seg", 32'(seg), 32'(displays[0]));

        // Three frames with distinct patterns; each digit lit CLK_DIV-BLANK cycles.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) en_cnt[i] = 0;
            repeat (FRAME) step();
            for (int i = 0; i < 8; i++) check("en_count", en_cnt[i], CLK_DIV - BLANK_CYCLES);
            for (int i = 0; i < 8; i++) displays[i] = 7'($urandom_range(0, 127));
        end

        // Mid-frame change of digit 3 must wait for the next frame.
        displays[3] = 7'h40;
        found = 0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            step();
            if ((k % FRAME) == 1) found = 1;
        end
        if (!found) check("wait_frame", 32'd0, 32'd1);
        found = 0;
        for (int c = 0; c < FRAME && !found; c++) begin
            step();
            if (an == 8'hF7) check("d3_old", 32'(seg), 32'h40);
            if (next_slot() == 5) found = 1;
        end
        if (!found) check("wait_idx5", 32'd0, 32'd1);
        displays[3] = 7'h79;
        for (int c = 0; c < FRAME + 16; c++) begin
            step();
            if (an == 8'hF7) check("d3_new", 32'(seg), 32'h79);
        end

        // Error blink, then immediate recovery.
        status = 2'b11;
        repeat (64) step();
        status = 2'b00;
        step();
        repeat (8) step();

        // Reset pulse while digit 6 is lit.
        found = 0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            if (next_slot() == 6 && (k % CLK_DIV) >= BLANK_CYCLES + 1) found = 1;
            else step();
        end
        if (!found) check("wait_idx6", 32'd0, 32'd1);
        reset = 1'b1;
        step();
        check("midrst_an", 32'(an), 32'hFF);
        check("midrst_seg", 32'(seg), 32'h7F);
        reset = 1'b0;
        step();
        check("restart_tick", 32'(frame_tick), 32'd1);
        step();
        check("restart_d0", 32'(an), 32'hFE);

        // Randomised run: digit updates, status changes, occasional resets.
        for (int c = 0; c < 40 * FRAME; c++) begin
            if ($urandom_range(0, 3) == 0) displays[$urandom_range(0, 7)] = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 39) == 0) status = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter CLK_DIV, default 50000: clock cycles per digit slot (blank + on); SHALL be > BLANK_CYCLES.
REQ-002 Parameter BLANK_CYCLES, default 500: anti-ghosting blank cycles at start of each slot; SHALL be >= 1.
REQ-003 Parameter BLINK_DIV, default 25000000: cycles per half-period of the error blink.
REQ-004 clock  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 displays  input  7 x 8 (unpacked [7:0] of [6:0])  active-low segment patterns from calc_top; index 0 = rightmost digit.
REQ-007 status  input  2  calculator status from calc_top.
REQ-008 an  output  8  active-low digit enables; bit i drives digit i.
REQ-009 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-010 dp  output  1  decimal point, active-low; constant 1 (off).
REQ-011 frame_tick  output  1  one-cycle pulse at each frame start.

Function
REQ-012 SHALL time-multiplex the 8 digits, one at a time, in order 0,1,...,7, then wrap to 0.
REQ-013 Each slot SHALL have two FSM states: S_BLANK (BLANK_CYCLES cycles, an=8'hFF) then S_ON (CLK_DIV-BLANK_CYCLES cycles, an bit idx=0, others 1).
REQ-014 Transitions: S_BLANK->S_ON when slot counter = BLANK_CYCLES-1; S_ON->S_BLANK when slot counter = CLK_DIV-1, with the counter cleared and idx incremented modulo 8.
REQ-015 On entry to S_BLANK with idx=0 (including the first cycle after reset), all 8 displays SHALL be copied into a shadow register and frame_tick SHALL be 1 for that cycle only.
REQ-016 seg SHALL be shadow[idx] during S_ON and 7'h7F during S_BLANK; changes to displays mid-frame SHALL NOT appear until the next frame.
REQ-017 an, seg and frame_tick SHALL be registered: one cycle latency from FSM state to pins.
REQ-018 Free-running blink counter SHALL toggle blink_off every BLINK_DIV cycles, independent of the scan.
REQ-019 When status = STATUS_ERR (2'b11) and blink_off=1, an SHALL be forced to 8'hFF; scan counters continue unaffected.
REQ-020 Status leaving STATUS_ERR SHALL restore normal an on the next registered update, regardless of blink phase.
REQ-021 Frame period SHALL be exactly 8*CLK_DIV cycles; no cycle lost at idx wrap.

Reset
REQ-022 While reset=1: an=8'hFF, seg=7'h7F, dp=1, frame_tick=0, idx=0, state=S_BLANK, slot and blink counters=0, blink_off=0, shadow all 7'h7F.
REQ-023 Reset asserted mid-slot SHALL abort the scan at the next edge; the first cycle after release SHALL be a frame start (REQ-015).

Structure
REQ-024 Package calc_pkg SHALL hold the FSM state enum (S_BLANK, S_ON), STATUS_ERR, SEG_OFF=7'h7F and AN_OFF=8'hFF.
REQ-025 One sub-module, blink_gen (counter + blink_off toggle), SHALL be used; the rest stays flat in display_scan.

Verification (bench parameters CLK_DIV=4, BLANK_CYCLES=1, BLINK_DIV=16)
REQ-026 Reset 2 cycles, release -> frame_tick visible 1 cycle later; then per 4-cycle slot: an=FF for 1 cycle, then an=FE for 3 cycles with seg=displays[0]; next slot an=FD; frame period = 32 cycles.
REQ-027 displays[3] changed from 7'h40 to 7'h79 while idx=5 -> digit 3 still shows 7'h40 for the rest of that frame, 7'h79 from the next frame.
REQ-028 status=2'b11 for 64 cycles -> an=FF for 16-cycle windows alternating with normal scan; status=2'b00 -> normal scan on the next cycle.
REQ-029 Reset asserted for 1 cycle while idx=6 in S_ON -> an=FF, seg=7F next cycle; after release the scan restarts at digit 0 with frame_tick.
REQ-030 Run 3 frames with distinct patterns on all 8 digits -> each digit enabled exactly 3 cycles per frame, never two an bits low at once, dp constantly 1.
